// File: rtl/adc_rp_rx.sv
// ADC capture path for the Red Pitaya front end.
// It registers the raw offset-binary codes for channels A and B and converts them to two's
// complement. It then averages and decimates by 2^k, and keeps sticky overrange flags.
// Optional build macro ADC_TEST_PATTERN_EN: adds tp_en, which replaces the formatted stage-2
// data with an internal ramp (A = ramp, B = ~ramp).
`timescale 1ns / 1ps

module adc_rp_rx #(
  parameter int unsigned DATA_WIDTH   = 14,
  parameter int unsigned MAX_DEC_LOG2 = 8,
  parameter int unsigned DEC_SEL_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] adc_dat_a,
  input  logic [DATA_WIDTH-1:0] adc_dat_b,
  input  logic                  ce,
  input  logic [DEC_SEL_W-1:0]  dec_log2,
  input  logic                  ovr_clr,
`ifdef ADC_TEST_PATTERN_EN
  input  logic                  tp_en,
`endif
  output logic [DATA_WIDTH-1:0] adc0,
  output logic [DATA_WIDTH-1:0] adc1,
  output logic                  valid,
  output logic                  ovr_a,
  output logic                  ovr_b
);

  localparam int unsigned AccW = DATA_WIDTH + MAX_DEC_LOG2;
  localparam logic [DATA_WIDTH-1:0] PosFs = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] NegFs = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [DATA_WIDTH-1:0]   s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic                    ce_s1_q, ce_s1_d;
  logic [DATA_WIDTH-1:0]   s2_a_q, s2_a_d, s2_b_q, s2_b_d;
  logic                    ce_s2_q, ce_s2_d;
  logic                    ovr_a_q, ovr_a_d, ovr_b_q, ovr_b_d;
  logic signed [AccW-1:0]  acc_a_q, acc_a_d, acc_b_q, acc_b_d;
  logic signed [AccW-1:0]  sum_a, sum_b;
  logic [MAX_DEC_LOG2-1:0] cnt_q, cnt_d, last_cnt;
  logic [DEC_SEL_W-1:0]    k_l_q, k_l_d, k_req, k_eff;
  logic [DATA_WIDTH-1:0]   adc0_q, adc0_d, adc1_q, adc1_d;
  logic                    valid_q, valid_d;
`ifdef ADC_TEST_PATTERN_EN
  logic [DATA_WIDTH-1:0]   ramp_q, ramp_d;
`endif

  // Pin register and offset-binary to two's-complement formatting.
  always_comb begin
    s1_a_d  = adc_dat_a;
    s1_b_d  = adc_dat_b;
    ce_s1_d = ce;
    s2_a_d  = {s1_a_q[DATA_WIDTH-1], ~s1_a_q[DATA_WIDTH-2:0]};
    s2_b_d  = {s1_b_q[DATA_WIDTH-1], ~s1_b_q[DATA_WIDTH-2:0]};
    ce_s2_d = ce_s1_q;
`ifdef ADC_TEST_PATTERN_EN
    ramp_d = ramp_q + DATA_WIDTH'(1);
    if (tp_en) begin
      s2_a_d = ramp_q;
      s2_b_d = ~ramp_q;
    end
`endif
  end

  // Sticky overrange flags; a new overrange sample wins over a simultaneous clear.
  always_comb begin
    ovr_a_d = (ovr_a_q && !ovr_clr) || (ce_s2_q && (s2_a_q == PosFs || s2_a_q == NegFs));
    ovr_b_d = (ovr_b_q && !ovr_clr) || (ce_s2_q && (s2_b_q == PosFs || s2_b_q == NegFs));
  end

  // Accumulate/decimate; the exponent is sampled live at block start and then frozen in k_l.
  always_comb begin
    k_req = dec_log2;
    if (32'(dec_log2) > MAX_DEC_LOG2) begin
      k_req = DEC_SEL_W'(MAX_DEC_LOG2);
    end
    k_eff    = (cnt_q == '0) ? k_req : k_l_q;
    k_l_d    = k_eff;
    last_cnt = MAX_DEC_LOG2'((32'd1 << k_eff) - 32'd1);
    sum_a    = acc_a_q + {{MAX_DEC_LOG2{s2_a_q[DATA_WIDTH-1]}}, s2_a_q};
    sum_b    = acc_b_q + {{MAX_DEC_LOG2{s2_b_q[DATA_WIDTH-1]}}, s2_b_q};
    acc_a_d  = acc_a_q;
    acc_b_d  = acc_b_q;
    cnt_d    = cnt_q;
    adc0_d   = adc0_q;
    adc1_d   = adc1_q;
    valid_d  = 1'b0;
    if (ce_s2_q) begin
      if (cnt_q == last_cnt) begin
        adc0_d  = DATA_WIDTH'(sum_a >>> k_eff);
        adc1_d  = DATA_WIDTH'(sum_b >>> k_eff);
        valid_d = 1'b1;
        acc_a_d = '0;
        acc_b_d = '0;
        cnt_d   = '0;
      end else begin
        acc_a_d = sum_a;
        acc_b_d = sum_b;
        cnt_d   = cnt_q + MAX_DEC_LOG2'(1);
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_a_q  <= '0;
      s1_b_q  <= '0;
      ce_s1_q <= 1'b0;
      s2_a_q  <= '0;
      s2_b_q  <= '0;
      ce_s2_q <= 1'b0;
      ovr_a_q <= 1'b0;
      ovr_b_q <= 1'b0;
      acc_a_q <= '0;
      acc_b_q <= '0;
      cnt_q   <= '0;
      k_l_q   <= '0;
      adc0_q  <= '0;
      adc1_q  <= '0;
      valid_q <= 1'b0;
`ifdef ADC_TEST_PATTERN_EN
      ramp_q  <= '0;
`endif
    end else begin
      s1_a_q  <= s1_a_d;
      s1_b_q  <= s1_b_d;
      ce_s1_q <= ce_s1_d;
      s2_a_q  <= s2_a_d;
      s2_b_q  <= s2_b_d;
      ce_s2_q <= ce_s2_d;
      ovr_a_q <= ovr_a_d;
      ovr_b_q <= ovr_b_d;
      acc_a_q <= acc_a_d;
      acc_b_q <= acc_b_d;
      cnt_q   <= cnt_d;
      k_l_q   <= k_l_d;
      adc0_q  <= adc0_d;
      adc1_q  <= adc1_d;
      valid_q <= valid_d;
`ifdef ADC_TEST_PATTERN_EN
      ramp_q  <= ramp_d;
`endif
    end
  end

  assign adc0  = adc0_q;
  assign adc1  = adc1_q;
  assign valid = valid_q;
  assign ovr_a = ovr_a_q;
  assign ovr_b = ovr_b_q;

endmodule

// File: tb/tb_adc_rp_rx.sv
// Self-checking bench for adc_rp_rx (default build): format table, decimation, ce gaps,
// exponent change mid-block, exponent clamp at full scale, overrange flags, async reset.
`timescale 1ns / 1ps

module tb_adc_rp_rx;

  localparam int W = 14;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] adc_dat_a, adc_dat_b;
  logic         ce;
  logic [3:0]   dec_log2;
  logic         ovr_clr;
  logic [W-1:0] adc0, adc1;
  logic         valid, ovr_a, ovr_b;

  int n_tests = 0;
  int n_fail  = 0;

  // Valid-strobe monitor, sampled mid-cycle.
  int           v_total = 0;
  logic [W-1:0] last_a = '0, last_b = '0;

  adc_rp_rx dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .adc_dat_a(adc_dat_a),
    .adc_dat_b(adc_dat_b),
    .ce       (ce),
    .dec_log2 (dec_log2),
    .ovr_clr  (ovr_clr),
    .adc0     (adc0),
    .adc1     (adc1),
    .valid    (valid),
    .ovr_a    (ovr_a),
    .ovr_b    (ovr_b)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid) begin
      v_total <= v_total + 1;
      last_a  <= adc0;
      last_b  <= adc1;
    end
  end

  typedef struct {
    logic [W-1:0] raw_a;
    logic [W-1:0] raw_b;
    logic [W-1:0] exp_a;
    logic [W-1:0] exp_b;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] f14(input int v);
    return {18'b0, v[13:0]};
  endfunction

  // Raw pin code whose converted value is v (conversion is 8191 - raw, modulo 2^14).
  function automatic logic [W-1:0] enc(input int v);
    int r;
    r = 8191 - v;
    return r[13:0];
  endfunction

  task automatic send(input int a, input int b);
    adc_dat_a = enc(a);
    adc_dat_b = enc(b);
    ce = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    ce = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int start;

  initial begin
    vecs[0] = '{raw_a: 14'h0000, raw_b: 14'h1000, exp_a: 14'h1FFF, exp_b: 14'h0FFF};
    vecs[1] = '{raw_a: 14'h2000, raw_b: 14'h3000, exp_a: 14'h3FFF, exp_b: 14'h2FFF};
    vecs[2] = '{raw_a: 14'h3FFF, raw_b: 14'h2005, exp_a: 14'h2000, exp_b: 14'h3FFA};
    vecs[3] = '{raw_a: 14'h1FFF, raw_b: 14'h0100, exp_a: 14'h0000, exp_b: 14'h1EFF};
    vecs[4] = '{raw_a: 14'h1F9B, raw_b: 14'h1FFE, exp_a: 14'h0064, exp_b: 14'h0001};

    rst_n = 1'b0; adc_dat_a = '0; adc_dat_b = '0; ce = 1'b0; dec_log2 = '0; ovr_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset adc0", {18'b0, adc0}, 32'h0);
    check("reset adc1", {18'b0, adc1}, 32'h0);
    check("reset valid", {31'b0, valid}, 32'h0);
    check("reset ovr_a", {31'b0, ovr_a}, 32'h0);
    check("reset ovr_b", {31'b0, ovr_b}, 32'h0);
    rst_n = 1'b1;
    idle(2);

    // Format table, k=0, back-to-back samples; outputs lag the pins by three edges.
    for (int i = 0; i < 7; i++) begin
      if (i < 5) begin
        adc_dat_a = vecs[i].raw_a;
        adc_dat_b = vecs[i].raw_b;
        ce = 1'b1;
      end else begin
        ce = 1'b0;
      end
      @(posedge clk);
      #1;
      if (i >= 2) begin
        check($sformatf("fmt%0d adc0", i - 2), {18'b0, adc0}, {18'b0, vecs[i-2].exp_a});
        check($sformatf("fmt%0d adc1", i - 2), {18'b0, adc1}, {18'b0, vecs[i-2].exp_b});
        check($sformatf("fmt%0d valid", i - 2), {31'b0, valid}, 32'h1);
      end
    end
    idle(3);
    check("ovr_a held after full-scale", {31'b0, ovr_a}, 32'h1);
    check("ovr_b clear", {31'b0, ovr_b}, 32'h0);

    // Overrange: clear alone, then set and clear in the same cycle.
    ovr_clr = 1'b1;
    idle(1);
    ovr_clr = 1'b0;
    check("ovr_a cleared", {31'b0, ovr_a}, 32'h0);
    check("ovr_b after clear", {31'b0, ovr_b}, 32'h0);
    send(8191, 0);
    idle(1);
    ovr_clr = 1'b1;
    idle(1);
    ovr_clr = 1'b0;
    check("ovr_a set beats clear", {31'b0, ovr_a}, 32'h1);
    check("ovr_b not set", {31'b0, ovr_b}, 32'h0);
    ovr_clr = 1'b1;
    idle(1);
    ovr_clr = 1'b0;
    check("ovr_a clear alone", {31'b0, ovr_a}, 32'h0);
    idle(3);

    // Decimate k=2.
    dec_log2 = 4'd2;
    start = v_total;
    send(100, 4); send(200, 4); send(-50, 4); send(10, 4);
    idle(6);
    check("k2 blk1 valid count", v_total - start, 32'd1);
    check("k2 blk1 adc0", {18'b0, last_a}, f14(65));
    check("k2 blk1 adc1", {18'b0, last_b}, f14(4));
    start = v_total;
    send(-1, -3); send(-1, -3); send(-1, -3); send(-2, -3);
    idle(6);
    check("k2 blk2 valid count", v_total - start, 32'd1);
    check("k2 blk2 adc0", {18'b0, last_a}, f14(-2));
    check("k2 blk2 adc1", {18'b0, last_b}, f14(-3));

    // ce gap, k=1: the discarded sample must not count.
    dec_log2 = 4'd1;
    start = v_total;
    send(10, 7);
    adc_dat_a = enc(500); adc_dat_b = enc(500);
    idle(1);
    send(20, 8);
    idle(6);
    check("gap valid count", v_total - start, 32'd1);
    check("gap adc0", {18'b0, last_a}, f14(15));
    check("gap adc1", {18'b0, last_b}, f14(7));

    // dec_log2 change after two samples are in the block.
    dec_log2 = 4'd2;
    start = v_total;
    send(1, 0); send(2, 0);
    idle(2);
    dec_log2 = 4'd0;
    send(3, 0); send(4, 0);
    idle(6);
    check("chg block valid count", v_total - start, 32'd1);
    check("chg block adc0", {18'b0, last_a}, f14(2));
    start = v_total;
    send(40, 1); send(50, 2);
    idle(6);
    check("chg k0 valid count", v_total - start, 32'd2);
    check("chg k0 adc0", {18'b0, last_a}, f14(50));

    // Exponent clamp (15 -> 8) with full-scale samples for accumulator headroom.
    dec_log2 = 4'd15;
    start = v_total;
    for (int i = 0; i < 255; i++) send(-8192, 8191);
    idle(4);
    check("clamp no early valid", v_total - start, 32'd0);
    send(-8192, 8191);
    idle(6);
    check("clamp valid count", v_total - start, 32'd1);
    check("clamp adc0", {18'b0, last_a}, f14(-8192));
    check("clamp adc1", {18'b0, last_b}, f14(8191));
    check("clamp ovr_a", {31'b0, ovr_a}, 32'h1);
    check("clamp ovr_b", {31'b0, ovr_b}, 32'h1);

    // Asynchronous reset mid-stream.
    dec_log2 = 4'd0;
    send(500, 600); send(501, 601); send(502, 602);
    send(503, 603);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst adc0", {18'b0, adc0}, 32'h0);
    check("async rst adc1", {18'b0, adc1}, 32'h0);
    check("async rst valid", {31'b0, valid}, 32'h0);
    check("async rst ovr_a", {31'b0, ovr_a}, 32'h0);
    check("async rst ovr_b", {31'b0, ovr_b}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(77, -77);
    ce = 1'b0;
    check("post-rst edge1 valid", {31'b0, valid}, 32'h0);
    idle(1);
    check("post-rst edge2 valid", {31'b0, valid}, 32'h0);
    idle(1);
    check("post-rst edge3 valid", {31'b0, valid}, 32'h1);
    check("post-rst adc0", {18'b0, adc0}, f14(77));
    check("post-rst adc1", {18'b0, adc1}, f14(-77));
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
